psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Accumulates a configurable number of unsigned products from the PE's wallace-tree multiplier onto an incoming partial sum, then presents the finished partial sum downstream. It sits directly after the multiplier in the PE datapath. Products, incoming psums and outgoing psums each use a valid/ready handshake. The block carries window state across cycles and holds its result under backpressure.

## Interface

- product_width, 8, width of multiplier product (in1_width + in2_width)
- psum_width, 12, width of psum_in, accumulator and psum_out; must be >= product_width
- len_width, 4, width of cfg_len

- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous abort of current window
- cfg_len  input  len_width  products per window; sampled only on psum_in handshake
- psum_in_valid  input  1  incoming psum valid
- psum_in  input  psum_width  incoming psum (accumulator seed)
- psum_in_ready  output  1  block accepts psum_in
- product_valid  input  1  multiplier product valid
- product_in  input  product_width  unsigned product
- product_ready  output  1  block accepts product
- psum_out_valid  output  1  finished psum valid
- psum_out  output  psum_width  finished psum
- psum_out_ready  input  1  downstream accepts psum_out
- overflow  output  1  sticky carry-out flag for the current or just-finished window
- busy  output  1  high in any state other than IDLE

## Operation

- States: IDLE, ACC, OUT.
- IDLE:
  - psum_in_ready=1.
  - On psum_in handshake: acc<=psum_in, remaining<=cfg_len, overflow<=0.
  - Next state is ACC if cfg_len!=0, else OUT.
- ACC:
  - product_ready=1.
  - On product handshake: acc<=(acc + zero-extended product_in) mod 2^psum_width, remaining<=remaining-1.
  - overflow<=1 if that sum carries out of bit psum_width-1. The flag stays set.
  - When the handshake consumes the last product (remaining==1), go to OUT.
- OUT:
  - psum_out_valid=1 and psum_out=acc, both held stable until psum_out_ready.
  - On handshake, go to IDLE.
  - The overflow value stays visible until the next psum_in handshake.
- Handshakes only occur in their owning state:
  - product_ready=0 outside ACC.
  - psum_in_ready=0 outside IDLE. There is no same-cycle OUT→IDLE→accept.
- clear=1 (any state): next state IDLE, acc<=0, remaining<=0, overflow<=0. Any handshake in the same cycle is ignored. clear has priority over all transitions.
- All arithmetic is unsigned. Wrap-around is modulo 2^psum_width.

## Timing

- Reset values: psum_in_ready=1, product_ready=0, psum_out_valid=0, psum_out=0, overflow=0, busy=0, state=IDLE, acc=0.
- rst_n low mid-window: immediately returns to the reset values above. The partial window is lost.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Start: psum_in handshake at edge N → ACC (or OUT) from cycle N+1. At most one product is accepted per cycle.
- Throughput: a continuously valid product stream is accepted every cycle in ACC.
- Finish: last product handshake at edge M → psum_out_valid=1 in cycle M+1. This includes the final product in psum_out.
- Window with cfg_len=0: psum_in at edge N → psum_out_valid=1 at cycle N+1, with psum_out=psum_in.
- Minimum window duration: cfg_len+2 cycles (accept, cfg_len products, output), plus one IDLE cycle before the next psum_in.
- product_valid asserted outside ACC is ignored. The product is not consumed.

## Test plan

- Reset: assert rst_n=0 mid-ACC → all outputs at reset values immediately; after release psum_in_ready=1, busy=0.
- Normal window: cfg_len=3, psum_in=10, products 15,20,25 back-to-back → psum_out=70 one cycle after the 3rd product, overflow=0, total 5 cycles from psum_in to psum_out_valid.
- Zero-length: cfg_len=0, psum_in=0x123 → psum_out_valid next cycle, psum_out=0x123, product_ready never high.
- Overflow/wrap: cfg_len=2, psum_in=0xFF0, products 0x20, 0x05 → psum_out=0x015, overflow=1. The next psum_in handshake clears overflow to 0.
- Backpressure and gaps:
  - cfg_len=2 with product_valid toggling 1,0,0,1 → exactly 2 products accumulated.
  - Then hold psum_out_ready=0 for 5 cycles → psum_out and psum_out_valid stable, psum_in_ready=0, product_ready=0.
  - Release → handshake, then IDLE.
- Abort: clear=1 in ACC after 1 of 3 products → IDLE next cycle, psum_out_valid never asserted. A following window with psum_in=5, cfg_len=1, product=7 → psum_out=12.

Source files
------------

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// psum_accumulator : adds cfg_len unsigned products onto a seeded partial sum
// Revision 1.0
// ============================================================================
module psum_accumulator #(
   parameter int PRODUCT_WIDTH = 8,
   parameter int PSUM_WIDTH    = 12,
   parameter int LEN_WIDTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [LEN_WIDTH-1:0]     cfg_len,
   input  logic                     psum_in_valid,
   input  logic [PSUM_WIDTH-1:0]    psum_in,
   output logic                     psum_in_ready,
   input  logic                     product_valid,
   input  logic [PRODUCT_WIDTH-1:0] product_in,
   output logic                     product_ready,
   output logic                     psum_out_valid,
   output logic [PSUM_WIDTH-1:0]    psum_out,
   input  logic                     psum_out_ready,
   output logic                     overflow,
   output logic                     busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t                  state_q;
   logic [PSUM_WIDTH-1:0]   acc_q;
   logic [LEN_WIDTH-1:0]    rem_q;
   logic                    ovf_q;
   logic [PSUM_WIDTH:0]     sum_d;

   // One extra bit captures the carry out of the accumulator MSB.
   assign sum_d = {1'b0, acc_q} +
                  {{(PSUM_WIDTH + 1 - PRODUCT_WIDTH){1'b0}}, product_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (clear) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (psum_in_valid) begin
                  acc_q   <= psum_in;
                  rem_q   <= cfg_len;
                  ovf_q   <= 1'b0;
                  state_q <= (cfg_len != '0) ? S_ACC : S_OUT;
               end
            end
            S_ACC: begin
               if (product_valid) begin
                  acc_q <= sum_d[PSUM_WIDTH-1:0];
                  rem_q <= rem_q - 1'b1;
                  if (sum_d[PSUM_WIDTH]) ovf_q <= 1'b1;
                  if (rem_q == LEN_WIDTH'(1)) state_q <= S_OUT;
               end
            end
            S_OUT: begin
               if (psum_out_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Handshake outputs are pure state decodes, so no input reaches an output.
   assign psum_in_ready  = (state_q == S_IDLE);
   assign product_ready  = (state_q == S_ACC);
   assign psum_out_valid = (state_q == S_OUT);
   assign psum_out       = acc_q;
   assign overflow       = ovf_q;
   assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
// tb_psum_accumulator : vector table plus corner sequences, queue scoreboard
// Revision 1.0
// ============================================================================
module tb_psum_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  cfg_len = '0;
   logic        psum_in_valid = 1'b0;
   logic [11:0] psum_in = '0;
   logic        psum_in_ready;
   logic        product_valid = 1'b0;
   logic [7:0]  product_in = '0;
   logic        product_ready;
   logic        psum_out_valid;
   logic [11:0] psum_out;
   logic        psum_out_ready = 1'b1;
   logic        overflow;
   logic        busy;

   psum_accumulator #(.PRODUCT_WIDTH(8), .PSUM_WIDTH(12), .LEN_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len),
      .psum_in_valid(psum_in_valid), .psum_in(psum_in), .psum_in_ready(psum_in_ready),
      .product_valid(product_valid), .product_in(product_in), .product_ready(product_ready),
      .psum_out_valid(psum_out_valid), .psum_out(psum_out), .psum_out_ready(psum_out_ready),
      .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]       len;
      logic [11:0]      seed;
      logic [15:0][7:0] prods;
      logic [11:0]      exp_out;
      logic             exp_ovf;
   } vec_t;

   typedef struct {
      logic [11:0] out;
      logic        ovf;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output handshake completes at the next rising edge if valid&&ready at negedge.
   always @(negedge clk) begin
      if (rst_n && psum_out_valid && psum_out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_psum_out", 32'(psum_out_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_psum_out", 32'(psum_out), 32'(e.out));
            chk("sb_overflow", 32'(overflow), 32'(e.ovf));
         end
      end
   end

   task automatic accept(input logic [3:0] len, input logic [11:0] seed);
      int guard = 0;
      while (!psum_in_ready && guard < 20) begin
         tick();
         guard++;
      end
      if (!psum_in_ready) chk("psum_in_ready_timeout", 32'(psum_in_ready), 32'd1);
      cfg_len       = len;
      psum_in       = seed;
      psum_in_valid = 1'b1;
      tick();
      psum_in_valid = 1'b0;
      cfg_len       = 4'hA;
      chk("ovf_cleared_on_accept", 32'(overflow), 32'd0);
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic run_win(input vec_t v);
      sb_q.push_back('{out: v.exp_out, ovf: v.exp_ovf});
      accept(v.len, v.seed);
      if (v.len == 0) begin
         chk("zero_len_valid", 32'(psum_out_valid), 32'd1);
         chk("zero_len_out", 32'(psum_out), 32'(v.seed));
         chk("zero_len_no_prod_ready", 32'(product_ready), 32'd0);
      end
      for (int i = 0; i < int'(v.len); i++) begin
         chk("prod_ready_in_acc", 32'(product_ready), 32'd1);
         product_valid = 1'b1;
         product_in    = v.prods[i];
         tick();
      end
      product_valid = 1'b0;
      chk("finish_valid", 32'(psum_out_valid), 32'd1);
      chk("finish_out", 32'(psum_out), 32'(v.exp_out));
      tick();
      chk("idle_after_out", 32'(psum_in_ready), 32'd1);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{len: 4'd3,  seed: 12'd10,  prods: '0, exp_out: 12'd70,  exp_ovf: 1'b0};
      vecs[0].prods[0] = 8'd15; vecs[0].prods[1] = 8'd20; vecs[0].prods[2] = 8'd25;
      vecs[1] = '{len: 4'd0,  seed: 12'h123, prods: '0, exp_out: 12'h123, exp_ovf: 1'b0};
      vecs[2] = '{len: 4'd2,  seed: 12'hFF0, prods: '0, exp_out: 12'h015, exp_ovf: 1'b1};
      vecs[2].prods[0] = 8'h20; vecs[2].prods[1] = 8'h05;
      vecs[3] = '{len: 4'd1,  seed: 12'd5,   prods: '0, exp_out: 12'd12,  exp_ovf: 1'b0};
      vecs[3].prods[0] = 8'd7;
      // 0xFFF + 4*0xFF = 5115 -> 0x3FB with carry
      vecs[4] = '{len: 4'd4,  seed: 12'hFFF, prods: '0, exp_out: 12'h3FB, exp_ovf: 1'b1};
      for (int i = 0; i < 4; i++) vecs[4].prods[i] = 8'hFF;
      // 15*0xFF = 3825 = 0xEF1, no carry
      vecs[5] = '{len: 4'd15, seed: 12'd0,   prods: '0, exp_out: 12'hEF1, exp_ovf: 1'b0};
      for (int i = 0; i < 15; i++) vecs[5].prods[i] = 8'hFF;

      tick(); tick();
      chk("rst_in_ready", 32'(psum_in_ready), 32'd1);
      chk("rst_prod_ready", 32'(product_ready), 32'd0);
      chk("rst_out_valid", 32'(psum_out_valid), 32'd0);
      chk("rst_out", 32'(psum_out), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      product_valid = 1'b1;
      product_in    = 8'h55;
      tick(); tick();
      product_valid = 1'b0;
      chk("prod_ignored_idle", 32'(psum_out), 32'd0);

      for (int k = 0; k < 6; k++) begin
         if (k > 0) chk("ovf_sticky_until_accept", 32'(overflow), 32'(vecs[k-1].exp_ovf));
         run_win(vecs[k]);
      end

      // Gapped products then output backpressure; stray products in OUT are ignored.
      psum_out_ready = 1'b0;
      sb_q.push_back('{out: 12'd107, ovf: 1'b0});
      accept(4'd2, 12'd100);
      product_valid = 1'b1; product_in = 8'd3;  tick();
      product_valid = 1'b0; product_in = 8'd50; tick(); tick();
      chk("gap_still_acc", 32'(product_ready), 32'd1);
      product_valid = 1'b1; product_in = 8'd4;  tick();
      product_in = 8'h77;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(psum_out_valid), 32'd1);
         chk("bp_out", 32'(psum_out), 32'd107);
         chk("bp_in_ready", 32'(psum_in_ready), 32'd0);
         chk("bp_prod_ready", 32'(product_ready), 32'd0);
         tick();
      end
      product_valid  = 1'b0;
      psum_out_ready = 1'b1;
      tick();
      chk("bp_release_idle", 32'(psum_in_ready), 32'd1);
      chk("bp_release_busy", 32'(busy), 32'd0);

      // Abort after one of three products.
      accept(4'd3, 12'd9);
      product_valid = 1'b1; product_in = 8'd1; tick();
      clear = 1'b1; tick();
      clear = 1'b0; product_valid = 1'b0;
      chk("clear_idle", 32'(psum_in_ready), 32'd1);
      chk("clear_busy", 32'(busy), 32'd0);
      chk("clear_acc", 32'(psum_out), 32'd0);
      tick(); tick();
      run_win(vecs[3]);

      // Asynchronous reset mid-window.
      sb_q.push_back('{out: 12'd0, ovf: 1'b0});
      accept(4'd3, 12'd200);
      product_valid = 1'b1; product_in = 8'd8; tick();
      product_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      sb_q.delete();
      chk("arst_in_ready", 32'(psum_in_ready), 32'd1);
      chk("arst_prod_ready", 32'(product_ready), 32'd0);
      chk("arst_out_valid", 32'(psum_out_valid), 32'd0);
      chk("arst_out", 32'(psum_out), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 32'(psum_in_ready), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      run_win(vecs[0]);

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
